bram_frame_writer: RTL

//  Streams one processed RGB frame into the single-port image BRAM (clka/ena/wea/addra/dina).

---
 rtl/bram_frame_writer_pkg.sv | 23 ++
 rtl/bram_frame_writer_pixel_addr_counter.sv | 67 ++++++
 rtl/bram_frame_writer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/bram_frame_writer_pkg.sv
// Shared definitions for the image BRAM store: default geometry, the writer state
// encoding used by the read-side blocks, and a width helper for the pixel counters.
package bram_frame_writer_pkg;

    localparam int unsigned PIX_W_DEF     = 24;
    localparam int unsigned ADDR_W_DEF    = 17;
    localparam int unsigned IMG_W_DEF     = 300;
    localparam int unsigned IMG_H_DEF     = 300;
    localparam int unsigned BASE_ADDR_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } wr_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bram_frame_writer_pixel_addr_counter.sv
// Raster position tracker: column, line and flat BRAM address, all advanced by one per
// stored pixel so the address never needs a multiplier.
module pixel_addr_counter
    import bram_frame_writer_pkg::*;
#(
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned IMG_H     = IMG_H_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic              clka_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_in_line_o,
    output logic              last_in_frame_o
);

    localparam int unsigned       XW        = cnt_width(IMG_W);
    localparam int unsigned       YW        = cnt_width(IMG_H);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    assign last_in_line_o  = (x_q == X_LAST);
    assign last_in_frame_o = last_in_line_o && (y_q == Y_LAST);
    assign addr_o          = addr_q;

    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clr_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = ADDR_BASE;
        end else if (inc_i) begin
            addr_d = addr_q + ADDR_W'(1);
            if (last_in_line_o) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clka_i) begin
        if (rst_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= ADDR_BASE;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/bram_frame_writer.sv
// Stores one raster-order RGB frame from a valid/ready pixel stream into BRAM port A,
// aligning on sof and flagging sof/eol disagreements with the internal pixel count.
module bram_frame_writer
    import bram_frame_writer_pkg::*;
#(
    parameter int unsigned PIX_W     = PIX_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned IMG_W     = IMG_W_DEF,
    parameter int unsigned IMG_H     = IMG_H_DEF,
    parameter int unsigned BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [PIX_W-1:0]  dina,
    output logic              busy,
    output logic              done,
    output logic              err_sync
);

    wr_state_e         state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [PIX_W-1:0]  dina_q, dina_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              beat;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              err_set;
    logic [ADDR_W-1:0] cnt_addr;
    logic              last_in_line;
    logic              last_in_frame;

    pixel_addr_counter #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_cnt (
        .clka_i          (clka),
        .rst_i           (rst),
        .clr_i           (cnt_clr),
        .inc_i           (cnt_inc),
        .addr_o          (cnt_addr),
        .last_in_line_o  (last_in_line),
        .last_in_frame_o (last_in_frame)
    );

    assign s_ready = (state_q == ST_ARM) || (state_q == ST_WRITE);
    assign busy    = s_ready;
    assign beat    = s_valid && s_ready;

    // cnt_inc marks a beat that is stored; it drives the counter and the BRAM strobe.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        err_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (beat && s_sof) begin
                    cnt_inc = 1'b1;
                    state_d = last_in_frame ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (beat) begin
                    cnt_inc = 1'b1;
                    if (s_sof) begin
                        err_set = 1'b1;
                    end
                    if (last_in_frame) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (cnt_inc && (s_eol != last_in_line)) begin
            err_set = 1'b1;
        end
    end

    // Address and data hold their last written values between beats.
    always_comb begin
        wr_d    = cnt_inc;
        addra_d = cnt_inc ? cnt_addr : addra_q;
        dina_d  = cnt_inc ? s_data : dina_q;
        done_d  = (state_q == ST_DONE);
        err_d   = cnt_clr ? 1'b0 : (err_q || err_set);
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ena      = wr_q;
    assign wea      = wr_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign done     = done_q;
    assign err_sync = err_q;

endmodule
